// File: rtl/pds_pkg.sv
// Shared types and default timing constants for the PDS per-port power sequencer.
package pds_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INRUSH = 2'd1,
    ON     = 2'd2,
    FAULT  = 2'd3
  } port_state_e;

  localparam int DEF_INRUSH_CYC   = 16;
  localparam int DEF_OC_FILT      = 4;
  localparam int DEF_COOLDOWN_CYC = 64;
  localparam int DEF_FAULT_LIMIT  = 2;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pds_port_fsm.sv
// One port's power sequencer: IDLE -> INRUSH -> ON, with FAULT on timeout, OC or pgood loss.
module pds_port_fsm
  import pds_pkg::*;
#(
  parameter int INRUSH_CYC   = DEF_INRUSH_CYC,
  parameter int OC_FILT      = DEF_OC_FILT,
  parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic on,
  input  logic oc,
  input  logic pgood,
  input  logic clr_fault,
  output logic gate_en,
  output logic pwr_good,
  output logic off,
  output logic fault,
  output logic next_fault
);

  localparam int RW = cnt_width(INRUSH_CYC);
  localparam int OW = cnt_width(OC_FILT);
  localparam int CW = cnt_width(COOLDOWN_CYC);

  localparam logic [RW-1:0] RAMP_END = RW'(INRUSH_CYC - 1);
  localparam logic [OW-1:0] OC_END   = OW'(OC_FILT);
  localparam logic [CW-1:0] COOL_END = CW'(COOLDOWN_CYC - 1);

  port_state_e     state_reg, state_next;
  logic [RW-1:0]   ramp_reg, ramp_next;
  logic [OW-1:0]   oc_reg, oc_next;
  logic [CW-1:0]   cool_reg, cool_next;

  always_comb begin
    state_next = state_reg;
    ramp_next  = '0;
    oc_next    = '0;
    cool_next  = '0;
    unique case (state_reg)
      IDLE: begin
        if (on) state_next = INRUSH;
      end
      INRUSH: begin
        if (ramp_reg == RAMP_END) begin
          // Timeout outranks a simultaneous grant drop.
          ramp_next = ramp_reg;
          if (!pgood)   state_next = FAULT;
          else if (!on) state_next = IDLE;
          else          state_next = ON;
        end else begin
          ramp_next = ramp_reg + RW'(1);
          if (!on) state_next = IDLE;
        end
      end
      ON: begin
        if (oc) oc_next = (oc_reg == OC_END) ? oc_reg : oc_reg + OW'(1);
        if ((oc && oc_next == OC_END) || !pgood) state_next = FAULT;
        else if (!on)                            state_next = IDLE;
      end
      FAULT: begin
        cool_next = (cool_reg == COOL_END) ? cool_reg : cool_reg + CW'(1);
        if (clr_fault || cool_reg == COOL_END) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign next_fault = (state_next == FAULT);

  // Outputs are decoded from the next state so they register with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ramp_reg  <= '0;
      oc_reg    <= '0;
      cool_reg  <= '0;
      gate_en   <= 1'b0;
      pwr_good  <= 1'b0;
      off       <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ramp_reg  <= ramp_next;
      oc_reg    <= oc_next;
      cool_reg  <= cool_next;
      gate_en   <= (state_next == INRUSH) || (state_next == ON);
      pwr_good  <= (state_next == ON);
      off       <= (state_next == FAULT);
      fault     <= (state_next == FAULT);
    end
  end

endmodule

// File: rtl/pds_port_seq.sv
// Array of per-port sequencers plus the global ports_off request driven by fault population.
module pds_port_seq
  import pds_pkg::*;
#(
  parameter int numPorts     = 4,
  parameter int INRUSH_CYC   = DEF_INRUSH_CYC,
  parameter int OC_FILT      = DEF_OC_FILT,
  parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
  parameter int FAULT_LIMIT  = DEF_FAULT_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [numPorts-1:0] on,
  input  logic [numPorts-1:0] oc,
  input  logic [numPorts-1:0] pgood,
  input  logic                clr_fault,
  output logic [numPorts-1:0] gate_en,
  output logic [numPorts-1:0] pwr_good,
  output logic [numPorts-1:0] off,
  output logic [numPorts-1:0] fault,
  output logic                ports_off
);

  localparam int FW = cnt_width(numPorts);

  logic [numPorts-1:0] next_fault;
  logic [FW-1:0]       fault_cnt;

  for (genvar gi = 0; gi < numPorts; gi++) begin : g_port
    pds_port_fsm #(
      .INRUSH_CYC   (INRUSH_CYC),
      .OC_FILT      (OC_FILT),
      .COOLDOWN_CYC (COOLDOWN_CYC)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .on         (on[gi]),
      .oc         (oc[gi]),
      .pgood      (pgood[gi]),
      .clr_fault  (clr_fault),
      .gate_en    (gate_en[gi]),
      .pwr_good   (pwr_good[gi]),
      .off        (off[gi]),
      .fault      (fault[gi]),
      .next_fault (next_fault[gi])
    );
  end

  // Counting next-state faults lets ports_off rise together with fault.
  always_comb begin
    fault_cnt = '0;
    for (int i = 0; i < numPorts; i++) fault_cnt = fault_cnt + FW'(next_fault[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ports_off <= 1'b0;
    else        ports_off <= (fault_cnt >= FW'(FAULT_LIMIT));
  end

endmodule

// File: tb/tb_pds_port_seq.sv
// Directed bench for pds_port_seq: expected output vectors are queued per step and popped after the edge.
module tb_pds_port_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] on, oc, pgood;
  logic       clr_fault;
  logic [3:0] gate_en, pwr_good, off, fault;
  logic       ports_off;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [16:0] val;
  } exp_t;

  exp_t sb[$];

  pds_port_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .on        (on),
    .oc        (oc),
    .pgood     (pgood),
    .clr_fault (clr_fault),
    .gate_en   (gate_en),
    .pwr_good  (pwr_good),
    .off       (off),
    .fault     (fault),
    .ports_off (ports_off)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] g, input logic [3:0] p,
                      input logic [3:0] o, input logic [3:0] f, input logic po);
    exp_t e;
    e.tag = tag;
    e.val = {g, p, o, f, po};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [16:0] obs;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=none expected=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {gate_en, pwr_good, off, fault, ports_off};
    checks++;
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s observed gate/pwr/off/fault/po=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] p,
                      input logic [3:0] o, input logic [3:0] f, input logic po);
    push(tag, g, p, o, f, po);
    tick();
    check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; on = '0; oc = '0; pgood = '0; clr_fault = 1'b0;
    ticks(2);
    push("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    check();
    rst_n = 1'b1;

    // Clean power-up of port 0.
    pgood = 4'hF; on = 4'b0001;
    step("t1_gate", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ticks(14);
    step("t1_inrush_end", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("t1_on", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Inrush timeout on port 1, then cooldown back to IDLE.
    pgood = 4'b1101; on = 4'b0011;
    step("t2_inrush", 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    ticks(14);
    step("t2_pre_timeout", 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    step("t2_timeout", 4'b0001, 4'b0001, 4'b0010, 4'b0010, 1'b0);
    on = 4'b0001;
    ticks(62);
    step("t2_cool_hold", 4'b0001, 4'b0001, 4'b0010, 4'b0010, 1'b0);
    step("t2_cool_done", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    pgood = 4'hF;

    // OC filter on port 2: 3-cycle glitch ignored, 4 consecutive cycles fault.
    on = 4'b0101;
    step("t3_inrush", 4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    ticks(15);
    step("t3_on", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    oc = 4'b0100;
    for (int i = 0; i < 3; i++) step("t3_glitch", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    oc = 4'b0000;
    step("t3_gap", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    oc = 4'b0100;
    for (int i = 0; i < 3; i++) step("t3_oc_run", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("t3_fault", 4'b0001, 4'b0001, 4'b0100, 4'b0100, 1'b0);
    oc = 4'b0000; on = 4'b0001; clr_fault = 1'b1;
    step("t3_clr", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    clr_fault = 1'b0;

    // Simultaneous faults on ports 0 and 3 raise ports_off with fault.
    on = 4'b1001;
    step("t4_inrush", 4'b1001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    ticks(15);
    step("t4_on", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    oc = 4'b1001;
    for (int i = 0; i < 3; i++) step("t4_oc_run", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    step("t4_dual_fault", 4'b0000, 4'b0000, 4'b1001, 4'b1001, 1'b1);
    on = 4'b0000;
    step("t4_on_ignored", 4'b0000, 4'b0000, 4'b1001, 4'b1001, 1'b1);
    oc = 4'b0000; clr_fault = 1'b1;
    step("t4_clr", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    clr_fault = 1'b0;

    // Grant drop in the same cycle the filter completes: fault wins.
    on = 4'b0100;
    step("t5_inrush", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ticks(15);
    step("t5_on", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    oc = 4'b0100;
    for (int i = 0; i < 3; i++) step("t5_oc_run", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    on = 4'b0000;
    step("t5_fault_wins", 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    oc = 4'b0000; clr_fault = 1'b1;
    step("t5_clr", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    clr_fault = 1'b0;

    // Mid-operation reset with port 0 ON and port 1 in FAULT.
    pgood = 4'b1101; on = 4'b0011;
    step("t6_inrush", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ticks(15);
    step("t6_on_fault", 4'b0001, 4'b0001, 4'b0010, 4'b0010, 1'b0);
    ticks(3);
    rst_n = 1'b0;
    #1;
    push("t6_async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check();
    pgood = 4'hF;
    rst_n = 1'b1;
    step("t6_restart", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ticks(14);
    step("t6_ramp_full", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("t6_on", 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    on = 4'b0000;
    step("t6_drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
